// File: rtl/divider_8bit_if.sv
// Start/operand/result bundle for the sequential restoring divider.
interface divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  q, r, dz, busy, done
    );

    modport slave (
        input  start, a, b,
        output q, r, dz, busy, done
    );
endinterface

// File: rtl/divider_8bit.sv
// Unsigned restoring divider: one quotient bit per clock, divide-by-zero short-circuits to DONE.
//   state  | meaning
//   IDLE   | waiting for start; results held
//   RUN    | one restoring step per edge, down-counter tracks remaining steps
//   DONE   | results valid, done pulse for one cycle
module divider_8bit #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    divider_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH:0]   rem_step;

    // A set top remainder bit means the shifted value already exceeds any divisor.
    always_comb begin
        rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, div_q};
        borrow   = ~rem_q[WIDTH] & trial[WIDTH];
        quo_step = {quo_q[WIDTH-2:0], ~borrow};
        rem_step = borrow ? rem_sh : trial;
    end

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.b != '0) begin
                        quo_d   = bus.a;
                        div_d   = bus.b;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        q_d     = '1;
                        r_d     = bus.a;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    q_d     = quo_step;
                    r_d     = rem_step[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_divider_8bit.sv
// Randomized and directed checks of divider_8bit against an arithmetic reference.
module tb_divider_8bit;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    divider_8bit_if #(.WIDTH(W)) bus ();

    divider_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result expected from plain integer division.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (bv == 0) ? {W{1'b1}} : W'(av / bv);
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (bv == 0) ? av : W'(av % bv);
    endfunction

    // Called at the negedge right after the start edge; counts cycles until done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy) busy_cnt++;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat, bc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        wait_done(lat, bc);
        check({tag, "_lat"}, lat, (bv != 0) ? W : 0);
        check({tag, "_busy"}, bc, (bv != 0) ? W + 1 : 1);
        check({tag, "_q"}, bus.q, ref_q(av, bv));
        check({tag, "_r"}, bus.r, ref_r(av, bv));
        check({tag, "_dz"}, bus.dz, (bv == 0));
        @(negedge clk);
        check({tag, "_done_1cyc"}, {bus.done, bus.busy}, 2'b00);
        check({tag, "_q_hold"}, {bus.q, bus.r}, {ref_q(av, bv), ref_r(av, bv)});
    endtask

    initial begin
        int lat, bc, ndone;
        logic [W-1:0] ra, rb;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #2;
        check("rst_state", {bus.q, bus.r, bus.dz, bus.busy, bus.done}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d64_7", 8'h64, 8'h07);
        run_op("dff_1", 8'hFF, 8'h01);
        run_op("dff_80", 8'hFF, 8'h80);
        run_op("d05_9", 8'h05, 8'h09);
        run_op("d00_3", 8'h00, 8'h03);
        run_op("d2a_0", 8'h2A, 8'h00);
        run_op("d10_4", 8'h10, 8'h04);

        // Second start during RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h64;
        bus.b     = 8'h07;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h02;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", lat + 5, W);
        check("ign_q", {bus.q, bus.r}, {8'h0E, 8'h02});
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("ign_no_2nd_done", ndone, 0);
        check("ign_hold", {bus.q, bus.r, bus.busy}, {8'h0E, 8'h02, 1'b0});

        // Start held high restarts after each DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h30;
        bus.b     = 8'h05;
        ndone     = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        bus.start = 1'b0;
        check("held_start_dones", ndone, 2);
        check("held_start_q", {bus.q, bus.r}, {8'h09, 8'h03});
        repeat (12) @(negedge clk);

        // Reset mid-operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        #1;
        check("rst_mid", {bus.q, bus.r, bus.dz, bus.busy, bus.done}, '0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("rst_start_ignored", ndone, 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_done", {bus.done, bus.busy}, 2'b00);
        run_op("dc8_a", 8'hC8, 8'h0A);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
